// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, S-box and round constants for the key schedule
package aes_pkg;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_t;
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };
endpackage

// File: rtl/aes_key_sched_if.sv
// aes_key_sched_if: key load / status / round-key read bundle
//   master drives key, key_load, rd_idx; slave returns busy, keys_rdy, rd_key
interface aes_key_sched_if;
    import aes_pkg::*;
    block_t      key;
    logic        key_load;
    logic        busy;
    logic        keys_rdy;
    logic [3:0]  rd_idx;
    block_t      rd_key;
    modport master (output key, key_load, rd_idx, input busy, keys_rdy, rd_key);
    modport slave  (input key, key_load, rd_idx, output busy, keys_rdy, rd_key);
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational SubWord, four parallel S-box lookups
//   w_i: input word, w_o: byte-wise substituted word
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t w_i,
    output word_t w_o
);
    assign w_o = {SBOX[w_i[31:24]], SBOX[w_i[23:16]], SBOX[w_i[15:8]], SBOX[w_i[7:0]]};
endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128 key expansion, one round key per clock
//   clk, rst: clock and synchronous active-high reset
//   bus.key/key_load: cipher key and load strobe (load restarts from any state)
//   bus.busy/keys_rdy: expansion running / all 11 round keys valid
//   bus.rd_idx/rd_key: registered round-key read, 0 for indices above NR
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input logic clk,
    input logic rst,
    aes_key_sched_if.slave bus
);
    ks_state_t  state_q;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       rdy_q;
    block_t     rk_q [NR+1];
    block_t     rd_key_q;
    block_t     prev;
    block_t     rk_d;
    block_t     rd_d;
    logic [7:0] rc;
    logic       cnt_ok;
    word_t      sub;
    word_t      t;
    word_t      n0, n1, n2, n3;
    // cnt indexes the entry being produced; its predecessor feeds the round
    assign cnt_ok = cnt_q != 4'd0 && cnt_q <= 4'(NR);
    assign prev   = cnt_ok ? rk_q[cnt_q - 4'd1] : '0;
    assign rc     = cnt_ok ? RCON[cnt_q - 4'd1] : 8'h0;
    aes_sub_word u_sub (
        .w_i ({prev[23:0], prev[31:24]}),
        .w_o (sub)
    );
    assign t    = sub ^ {rc, 24'h0};
    assign n0   = prev[127:96] ^ t;
    assign n1   = prev[95:64] ^ n0;
    assign n2   = prev[63:32] ^ n1;
    assign n3   = prev[31:0] ^ n2;
    assign rk_d = {n0, n1, n2, n3};
    assign rd_d = bus.rd_idx <= 4'(NR) ? rk_q[bus.rd_idx] : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
            rd_key_q <= '0;
            rk_q     <= '{default: '0};
        end else begin
            rd_key_q <= rd_d;
            if (bus.key_load) begin
                rk_q[0] <= bus.key;
                cnt_q   <= 4'd1;
                busy_q  <= 1'b1;
                rdy_q   <= 1'b0;
                state_q <= EXPAND;
            end else if (state_q == EXPAND) begin
                rk_q[cnt_q] <= rk_d;
                cnt_q       <= cnt_q + 4'd1;
                if (cnt_q == 4'(NR)) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            end
        end
    end
    assign bus.busy     = busy_q;
    assign bus.keys_rdy = rdy_q;
    assign bus.rd_key   = rd_key_q;
endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: randomized and directed checks of aes_key_sched against a FIPS-197 word model
module tb_aes_key_sched;
    import aes_pkg::*;
    localparam block_t FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam block_t FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam block_t ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam block_t ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    logic [7:0] sb [256];
    block_t exp_rk [11];
    always #5 clk = ~clk;
    aes_key_sched_if bus ();
    aes_key_sched #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    function automatic logic [7:0] xtime(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction
    function automatic logic [7:0] rotl(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction
    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask
    // FIPS-197 KeyExpansion over the flat 44-word array
    task automatic expand(input block_t k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0] rcv = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rcv, 24'h0};
                rcv = xtime(rcv);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic block_t rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic read_rk(input int i, output block_t v);
        bus.rd_idx = 4'(i);
        tick();
        v = bus.rd_key;
    endtask
    task automatic pulse_load(input block_t k);
        bus.key = k;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        bus.key = rand_block();
    endtask
    // n: edges after the load edge until keys_rdy; e: cycles with wrong busy
    task automatic wait_rdy(output int n, output int e);
        n = 0;
        e = 0;
        while (!bus.keys_rdy && n < 30) begin
            if (!bus.busy) e++;
            tick();
            n++;
        end
        if (bus.busy) e++;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.keys_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", bus.keys_rdy); end
        total++; if (bus.rd_key !== '0) begin bad++; $display("FAIL reset_rd_key got=%h want=0", bus.rd_key); end
        rst = 1'b0;
    endtask
    task automatic test_fips();
        int n, e;
        block_t v;
        pulse_load(FIPS_KEY);
        wait_rdy(n, e);
        total++; if (n !== 10) begin bad++; $display("FAIL fips_latency got=%0d want=10", n); end
        total++; if (e !== 0) begin bad++; $display("FAIL fips_busy got=%0d bad cycles want=0", e); end
        read_rk(1, v);
        total++; if (v !== FIPS_RK1) begin bad++; $display("FAIL fips_rk1 got=%h want=%h", v, FIPS_RK1); end
        read_rk(10, v);
        total++; if (v !== FIPS_RK10) begin bad++; $display("FAIL fips_rk10 got=%h want=%h", v, FIPS_RK10); end
        expand(FIPS_KEY);
        for (int i = 0; i < 11; i++) begin
            read_rk(i, v);
            total++; if (v !== exp_rk[i]) begin bad++; $display("FAIL fips_rk[%0d] got=%h want=%h", i, v, exp_rk[i]); end
        end
    endtask
    task automatic test_zero();
        int n, e;
        block_t v;
        pulse_load('0);
        wait_rdy(n, e);
        total++; if (n !== 10) begin bad++; $display("FAIL zero_latency got=%0d want=10", n); end
        read_rk(1, v);
        total++; if (v !== ZERO_RK1) begin bad++; $display("FAIL zero_rk1 got=%h want=%h", v, ZERO_RK1); end
        read_rk(10, v);
        total++; if (v !== ZERO_RK10) begin bad++; $display("FAIL zero_rk10 got=%h want=%h", v, ZERO_RK10); end
    endtask
    task automatic test_random();
        int n, e;
        block_t k, v;
        repeat (4) begin
            k = rand_block();
            pulse_load(k);
            wait_rdy(n, e);
            total++; if (n !== 10 || e !== 0) begin bad++; $display("FAIL rand_timing got=%0d/%0d want=10/0", n, e); end
            expand(k);
            for (int i = 0; i < 11; i++) begin
                read_rk(i, v);
                total++; if (v !== exp_rk[i]) begin bad++; $display("FAIL rand_rk[%0d] got=%h want=%h", i, v, exp_rk[i]); end
            end
        end
    endtask
    task automatic test_restart();
        int n, e;
        block_t v;
        pulse_load(FIPS_KEY);
        repeat (3) begin
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL restart_busy_pre got=%b want=1", bus.busy); end
            tick();
        end
        pulse_load('0);
        wait_rdy(n, e);
        total++; if (n !== 10) begin bad++; $display("FAIL restart_latency got=%0d want=10", n); end
        total++; if (e !== 0) begin bad++; $display("FAIL restart_busy got=%0d bad cycles want=0", e); end
        expand('0);
        for (int i = 0; i < 11; i++) begin
            read_rk(i, v);
            total++; if (v !== exp_rk[i]) begin bad++; $display("FAIL restart_rk[%0d] got=%h want=%h", i, v, exp_rk[i]); end
        end
    endtask
    task automatic test_reset_mid();
        int n, e;
        block_t v;
        pulse_load(FIPS_KEY);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
        total++; if (bus.keys_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_rdy got=%b want=0", bus.keys_rdy); end
        total++; if (bus.rd_key !== '0) begin bad++; $display("FAIL rstmid_rd_key got=%h want=0", bus.rd_key); end
        for (int i = 0; i < 11; i++) begin
            read_rk(i, v);
            total++; if (v !== '0) begin bad++; $display("FAIL rstmid_rk[%0d] got=%h want=0", i, v); end
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b want=0", bus.busy); end
        pulse_load(FIPS_KEY);
        wait_rdy(n, e);
        total++; if (n !== 10) begin bad++; $display("FAIL rstmid_reload_latency got=%0d want=10", n); end
        read_rk(1, v);
        total++; if (v !== FIPS_RK1) begin bad++; $display("FAIL rstmid_rk1 got=%h want=%h", v, FIPS_RK1); end
        read_rk(10, v);
        total++; if (v !== FIPS_RK10) begin bad++; $display("FAIL rstmid_rk10 got=%h want=%h", v, FIPS_RK10); end
    endtask
    task automatic test_read_sweep();
        block_t v, want;
        expand(FIPS_KEY);
        for (int i = 0; i < 16; i++) begin
            read_rk(i, v);
            want = i < 11 ? exp_rk[i] : '0;
            total++; if (v !== want) begin bad++; $display("FAIL sweep_idx%0d got=%h want=%h", i, v, want); end
            if (i == 0) begin
                total++; if (v !== FIPS_KEY) begin bad++; $display("FAIL sweep_rk0_key got=%h want=%h", v, FIPS_KEY); end
            end
        end
    endtask
    task automatic test_load_rst();
        block_t v;
        rst = 1'b1;
        bus.key = rand_block();
        bus.key_load = 1'b1;
        tick();
        rst = 1'b0;
        bus.key_load = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.keys_rdy !== 1'b0) begin bad++; $display("FAIL ldrst_flags got=%b%b want=00", bus.busy, bus.keys_rdy); end
        tick();
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ldrst_idle got=%b want=0", bus.busy); end
        read_rk(0, v);
        total++; if (v !== '0) begin bad++; $display("FAIL ldrst_rk0 got=%h want=0", v); end
    endtask
    initial begin
        rst = 1'b1;
        bus.key = '0;
        bus.key_load = 1'b0;
        bus.rd_idx = 4'd0;
        build_sbox();
        test_reset();
        test_fips();
        test_zero();
        test_random();
        test_restart();
        test_reset_mid();
        test_read_sweep();
        test_load_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Iterative AES-128 key schedule that sits directly upstream of `aes_wrapper`'s round datapath. It expands a 128-bit cipher key into the 11 round keys, one round key per clock, and stores them in an internal register file. The round logic reads them by index. Expansion runs once per key load, so consecutive blocks under the same key need no recomputation.

## Interface
Parameters:
- `NR`, 10, number of rounds; fixed at 10 for AES-128; other values unsupported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `key`  in  128  cipher key; byte 0 = `key[127:120]`; word w0 = `key[127:96]`.
- `key_load`  in  1  start expansion; sampled on any rising edge.
- `busy`  out  1  expansion in progress.
- `keys_rdy`  out  1  all 11 round keys valid; level signal.
- `rd_idx`  in  4  round-key index, 0..10.
- `rd_key`  out  128  round key `rd_idx`, registered.

## Operation
The block has three states: IDLE, EXPAND and DONE.

- **IDLE**: the state after reset. `busy`=0, `keys_rdy`=0.
- **Load**: an edge with `key_load`=1 does the following, from any state:
  - writes rk[0] = `key`;
  - sets cnt = 1, `busy`=1, `keys_rdy`=0;
  - moves to EXPAND.
- **EXPAND**: each edge computes the next round key from the previous one.
  - Temp word t = SubWord(RotWord(w3)) xor {rcon[cnt], 24'h0}.
  - Next words: w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - rk[cnt] is written with the result; cnt increments.
  - When cnt==10 is written: go to DONE, `busy`=0, `keys_rdy`=1.
- **DONE**: holds the stored keys until the next `key_load` or `rst`.
- **Restart**: `key_load` while in EXPAND aborts the current expansion. The new key restarts expansion in the same edge. rk[] entries from the aborted key above the restart point are stale and are overwritten in the following cycles.
- **Read port**: `rd_key` <= rk[`rd_idx`] on every edge, in all states.
  - During EXPAND the port returns whatever is currently stored. Entries not yet rewritten are stale, which is legal.
  - `rd_idx` > 10 returns 128'h0.
- **Reset**: `rst` has priority over `key_load`. It clears state to IDLE, cnt to 0, `busy`, `keys_rdy` and `rd_key` to 0, and all rk[] to 0.
- **rcon**: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36 for cnt 1..10.

## Timing
- Reset values: `busy`=0, `keys_rdy`=0, `rd_key`=0.
- Latency:
  - The load edge is E0.
  - rk[k] is written at edge Ek.
  - `keys_rdy` rises after E10, i.e. 10 cycles after the load edge.
  - Total occupancy is 11 edges including the load edge.
- `busy` is high from after E0 through E9 and low after E10.
- `keys_rdy` and `busy` are never both high.
- `rd_key` read latency is 1 cycle from `rd_idx`.
- Data written at Ek is visible on `rd_key` after E(k+1) if `rd_idx`=k is held.
- `key` needs to be valid only at the load edge; it is not re-sampled afterwards.
- The S-box is combinational inside the EXPAND cycle. Four S-box lookups plus an XOR chain form a single-cycle path.

## Structure
- Package `aes_pkg`:
  - `SBOX` constant array, 256x8;
  - `RCON` constant array, 10x8;
  - type `word_t` = logic [31:0];
  - type `block_t` = logic [127:0];
  - state enum `ks_state_t` = {IDLE, EXPAND, DONE}.
- Sub-module `aes_sub_word`: a combinational 32-bit SubWord built from four S-box lookups. Reuse it if it is already shared with the round's SubBytes.
- Round-key storage is an 11-entry `block_t` register array. No RAM macro is required.

## Test plan
1. **FIPS-197 key**: `key`=2b7e151628aed2a6abf7158809cf4f3c, pulse `key_load`.
   - `keys_rdy` must rise 10 cycles later.
   - rk[1] = a0fafe1788542cb123a339392a6c7605.
   - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
2. **Zero key**: `key`=0.
   - rk[1] = 62636363626363636263636362636363.
   - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
3. **Restart mid-expansion**: load the FIPS key, then assert `key_load` with the zero key at E4.
   - `busy` stays high.
   - `keys_rdy` rises 10 cycles after the second load.
   - rk[] equals the zero-key schedule from scenario 2.
4. **Reset mid-EXPAND**: assert `rst` at E5.
   - The next cycle shows `busy`=0, `keys_rdy`=0, `rd_key`=0.
   - All indices read 0.
   - A subsequent FIPS key load produces the scenario-1 values.
5. **Read port**: in DONE, sweep `rd_idx` 0..15, one per cycle.
   - `rd_key` follows one cycle later.
   - rk[0] equals the loaded `key`.
   - Indices 11..15 return 0.
6. **Load and reset in the same edge**: assert `rst` and `key_load` together.
   - Reset wins: state IDLE, rk[0]=0.
